// File: rtl/acc_alu_seq_if.sv
// Handshake and data bundle between the control sequencer and acc_alu_seq.
// The master issues fn/operand with start; the slave returns results and flags.
interface acc_alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [7:0]       fn;
    logic [WIDTH-1:0] operand;
    logic             clr_acc;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mr;
    logic             busy;
    logic             done;
    logic             zero;
    logic             neg;
    logic             div_zero;
    logic             illegal;

    modport master (
        output start, fn, operand, clr_acc,
        input  acc, mr, busy, done, zero, neg, div_zero, illegal
    );

    modport slave (
        input  start, fn, operand, clr_acc,
        output acc, mr, busy, done, zero, neg, div_zero, illegal
    );
endinterface

// File: rtl/acc_alu_seq.sv
// Accumulator/ALU datapath with ACC, MR extension register and a
// multi-cycle unsigned shift-add multiplier and restoring divider.
module acc_alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    acc_alu_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             last;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mr_d    = mr_q;
        x_d     = x_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
        a_in    = bus.clr_acc ? '0 : acc_q;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        last    = (cnt_q == CNTW'(WIDTH - 1));

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    dz_d   = 1'b0;
                    ill_d  = 1'b0;
                    x_d    = bus.operand;
                    unique case (bus.fn)
                        8'h01, 8'h05, 8'h06, 8'h07: ;
                        8'h02: acc_d = bus.operand;
                        8'h03: acc_d = a_in + bus.operand;
                        8'h04: acc_d = a_in - bus.operand;
                        8'h0A: acc_d = a_in & bus.operand;
                        8'h0B: acc_d = a_in | bus.operand;
                        8'h0C: acc_d = ~bus.operand;
                        8'h0D: acc_d = {1'b0, a_in[WIDTH-1:1]};
                        8'h0E: acc_d = {a_in[WIDTH-2:0], 1'b0};
                        8'h0F: acc_d = ~a_in;
                        8'h08: begin
                            done_d  = 1'b0;
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            hi_d    = '0;
                            lo_d    = a_in;
                            state_d = S_MUL;
                        end
                        8'h09: begin
                            if (bus.operand == '0) begin
                                acc_d = '1;
                                mr_d  = a_in;
                                dz_d  = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                busy_d  = 1'b1;
                                cnt_d   = '0;
                                hi_d    = '0;
                                lo_d    = a_in;
                                state_d = S_DIV;
                            end
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                // hi accumulates partial products; lo shifts out multiplier bits
                sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    acc_d   = lo_d;
                    mr_d    = hi_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                // hi is the partial remainder, lo shifts dividend out and quotient in
                shifted = {hi_q, lo_q[WIDTH-1]};
                diff    = shifted - {1'b0, x_q};
                if (!diff[WIDTH]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    acc_d   = lo_d;
                    mr_d    = hi_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (done_d) begin
            zero_d = (acc_d == '0);
            neg_d  = acc_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mr_q    <= '0;
            x_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mr_q    <= mr_d;
            x_q     <= x_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.acc      = acc_q;
    assign bus.mr       = mr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.zero     = zero_q;
    assign bus.neg      = neg_q;
    assign bus.div_zero = dz_q;
    assign bus.illegal  = ill_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Randomised bench for acc_alu_seq against an arithmetic reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_acc_alu_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] m_acc, m_mr;
    logic         m_zero, m_neg, m_dz, m_ill;

    acc_alu_seq_if #(.WIDTH(W)) bus ();

    acc_alu_seq #(.WIDTH(W), .CNTW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = '0; m_mr = '0; m_zero = 1'b1;
        m_neg = 1'b0; m_dz = 1'b0; m_ill = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] f,
                               input logic [W-1:0] x,
                               input logic c);
        int unsigned a, xi;
        longint unsigned p;
        a = c ? 0 : int'(m_acc);
        xi = int'(x);
        m_dz = 1'b0;
        m_ill = 1'b0;
        case (f)
            8'h01, 8'h05, 8'h06, 8'h07: ;
            8'h02: m_acc = x;
            8'h03: m_acc = W'(a + xi);
            8'h04: m_acc = W'(a - xi);
            8'h0A: m_acc = W'(a & xi);
            8'h0B: m_acc = W'(a | xi);
            8'h0C: m_acc = W'(65535 - xi);
            8'h0D: m_acc = W'(a / 2);
            8'h0E: m_acc = W'(a * 2);
            8'h0F: m_acc = W'(65535 - a);
            8'h08: begin
                p = longint'(a) * longint'(xi);
                m_acc = W'(p % 65536);
                m_mr  = W'(p / 65536);
            end
            8'h09: begin
                if (xi == 0) begin
                    m_acc = '1;
                    m_mr  = W'(a);
                    m_dz  = 1'b1;
                end else begin
                    m_acc = W'(a / xi);
                    m_mr  = W'(a % xi);
                end
            end
            default: m_ill = 1'b1;
        endcase
        m_zero = (m_acc == '0);
        m_neg  = m_acc[W-1];
    endtask

    // Issue one op, wait for its done pulse and compare everything.
    task automatic do_op(input logic [7:0] f, input logic [W-1:0] x,
                         input logic c, input bit noise, input string nm);
        int busy_n, exp_busy;
        bit got, hold_bad;
        logic [W-1:0] pre_acc, pre_mr;
        pre_acc = m_acc;
        pre_mr = m_mr;
        exp_busy = (f == 8'h08 || (f == 8'h09 && x != '0)) ? W : 0;
        bus.start = 1'b1; bus.fn = f; bus.operand = x; bus.clr_acc = c;
        model_apply(f, x, c);
        @(posedge clk); #1;
        busy_n = 0; got = 1'b0; hold_bad = 1'b0;
        for (int i = 0; i < 3 * W && !got; i++) begin
            bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_n++;
                if (bus.acc !== pre_acc || bus.mr !== pre_mr) hold_bad = 1'b1;
                if (noise) begin
                    bus.start = 1'($urandom);
                    bus.fn = 8'($urandom);
                    bus.operand = W'($urandom);
                    bus.clr_acc = 1'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout got=0 want=1", nm);
        end
        checks++;
        if (busy_n != exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", nm, busy_n, exp_busy);
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s hold acc/mr changed before done want=%h/%h", nm, pre_acc, pre_mr);
        end
        checks++;
        if (bus.acc !== m_acc) begin
            errors++;
            $display("FAIL %s acc got=%h want=%h", nm, bus.acc, m_acc);
        end
        checks++;
        if (bus.mr !== m_mr) begin
            errors++;
            $display("FAIL %s mr got=%h want=%h", nm, bus.mr, m_mr);
        end
        checks++;
        if ({bus.zero, bus.neg, bus.div_zero, bus.illegal} !== {m_zero, m_neg, m_dz, m_ill}) begin
            errors++;
            $display("FAIL %s flags(z,n,dz,ill) got=%b want=%b", nm,
                     {bus.zero, bus.neg, bus.div_zero, bus.illegal}, {m_zero, m_neg, m_dz, m_ill});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done/busy after completion got=%b%b want=00", nm, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.fn = 8'h03; bus.operand = 16'h1234; bus.clr_acc = 1'b0;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.acc, bus.mr, bus.zero, bus.busy, bus.done} !== {32'h0, 3'b100}) begin
                errors++;
                $display("FAIL reset acc=%h mr=%h z=%b busy=%b done=%b want 0000 0000 1 0 0",
                         bus.acc, bus.mr, bus.zero, bus.busy, bus.done);
            end
        end
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(8'h02, 16'h0005, 1'b0, 1'b0, "load5");
        checks++;
        if (bus.acc !== 16'h0005) begin
            errors++;
            $display("FAIL load5_const acc got=%h want=0005", bus.acc);
        end
    endtask

    task automatic test_add_sub();
        do_op(8'h02, 16'h0003, 1'b0, 1'b0, "load3");
        do_op(8'h04, 16'h0005, 1'b0, 1'b0, "sub");
        checks++;
        if ({bus.acc, bus.neg, bus.zero} !== {16'hFFFE, 2'b10}) begin
            errors++;
            $display("FAIL sub_const acc=%h n=%b z=%b want FFFE 1 0", bus.acc, bus.neg, bus.zero);
        end
        do_op(8'h03, 16'h0002, 1'b0, 1'b0, "add_wrap");
        checks++;
        if ({bus.acc, bus.neg, bus.zero} !== {16'h0000, 2'b01}) begin
            errors++;
            $display("FAIL add_const acc=%h n=%b z=%b want 0000 0 1", bus.acc, bus.neg, bus.zero);
        end
    endtask

    task automatic test_mul();
        do_op(8'h02, 16'h1234, 1'b0, 1'b0, "load_mul");
        do_op(8'h08, 16'h0100, 1'b0, 1'b1, "mul_plan");
        checks++;
        if ({bus.mr, bus.acc} !== 32'h0012_3400) begin
            errors++;
            $display("FAIL mul_const mr:acc got=%h%h want=00123400", bus.mr, bus.acc);
        end
        do_op(8'h02, 16'hFFFF, 1'b0, 1'b0, "load_max");
        do_op(8'h08, 16'hFFFF, 1'b0, 1'b0, "mul_max");
        for (int i = 0; i < 4; i++) begin
            do_op(8'h02, W'($urandom), 1'b0, 1'b0, "load_rmul");
            do_op(8'h08, W'($urandom), 1'b0, 1'b1, "mul_rand");
        end
    endtask

    task automatic test_div();
        do_op(8'h02, 16'h0064, 1'b0, 1'b0, "load_div");
        do_op(8'h09, 16'h0007, 1'b0, 1'b1, "div_plan");
        checks++;
        if ({bus.acc, bus.mr} !== 32'h000E_0002) begin
            errors++;
            $display("FAIL div_const acc:mr got=%h%h want=000E0002", bus.acc, bus.mr);
        end
        do_op(8'h02, 16'h0010, 1'b0, 1'b0, "load_dz");
        do_op(8'h09, 16'h0000, 1'b0, 1'b0, "div_zero");
        checks++;
        if ({bus.acc, bus.mr, bus.div_zero} !== {32'hFFFF_0010, 1'b1}) begin
            errors++;
            $display("FAIL divz_const acc=%h mr=%h dz=%b want FFFF 0010 1", bus.acc, bus.mr, bus.div_zero);
        end
        do_op(8'h09, 16'hFFFF, 1'b0, 1'b0, "div_big");
        for (int i = 0; i < 4; i++) begin
            do_op(8'h02, W'($urandom), 1'b0, 1'b0, "load_rdiv");
            do_op(8'h09, W'($urandom_range(1, 300)), 1'b0, 1'b0, "div_rand");
        end
    endtask

    task automatic test_shift_illegal();
        do_op(8'h02, 16'h8001, 1'b0, 1'b0, "load_sh");
        do_op(8'h0D, 16'h0000, 1'b0, 1'b0, "shr");
        checks++;
        if (bus.acc !== 16'h4000) begin
            errors++;
            $display("FAIL shr_const acc got=%h want=4000", bus.acc);
        end
        do_op(8'h0E, 16'h0000, 1'b0, 1'b0, "shl");
        do_op(8'h0F, 16'h1234, 1'b1, 1'b0, "not_clr");
        checks++;
        if (bus.acc !== 16'hFFFF) begin
            errors++;
            $display("FAIL notclr_const acc got=%h want=FFFF", bus.acc);
        end
        do_op(8'h20, 16'h0055, 1'b0, 1'b0, "illegal");
        do_op(8'h01, 16'h0055, 1'b0, 1'b0, "noop_clear");
    endtask

    task automatic test_abort();
        bit seen;
        do_op(8'h02, W'($urandom), 1'b0, 1'b0, "load_abort");
        bus.start = 1'b1; bus.fn = 8'h08; bus.operand = 16'h0333; bus.clr_acc = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        checks++;
        if ({bus.acc, bus.mr, bus.busy, bus.done} !== {32'h0, 2'b00}) begin
            errors++;
            $display("FAIL abort acc=%h mr=%h busy=%b done=%b want 0000 0000 0 0",
                     bus.acc, bus.mr, bus.busy, bus.done);
        end
        seen = 1'b0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet done/busy seen=1 want=0");
        end
        do_op(8'h02, 16'h0009, 1'b0, 1'b0, "load_post");
        do_op(8'h08, 16'h0007, 1'b0, 1'b0, "mul_post");
    endtask

    task automatic test_back_to_back();
        bit got;
        do_op(8'h02, 16'h0102, 1'b0, 1'b0, "load_b2b");
        bus.start = 1'b1; bus.fn = 8'h08; bus.operand = 16'h0203; bus.clr_acc = 1'b0;
        model_apply(8'h08, 16'h0203, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3 * W && !got; i++) begin
            if (bus.done) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!got || bus.acc !== m_acc || bus.mr !== m_mr) begin
            errors++;
            $display("FAIL b2b_mul got_done=%b acc=%h mr=%h want 1 %h %h", got, bus.acc, bus.mr, m_acc, m_mr);
        end
        bus.start = 1'b1; bus.fn = 8'h03; bus.operand = 16'h1111; bus.clr_acc = 1'b0;
        model_apply(8'h03, 16'h1111, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.acc !== m_acc || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_add done=%b busy=%b acc=%h want 1 0 %h", bus.done, bus.busy, bus.acc, m_acc);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse done got=%b want=0", bus.done);
        end
    endtask

    task automatic test_random();
        logic [7:0] codes [16];
        logic [7:0] f;
        logic [W-1:0] x;
        int k;
        codes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h00};
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 16));
            f = (k == 16) ? 8'($urandom_range(16, 255)) : codes[k];
            x = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_op(f, x, 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.fn = '0; bus.operand = '0; bus.clr_acc = 1'b0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_shift_illegal();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
- Parametrised accumulator/ALU datapath: ACC, MR/DR extension register and ALU in one block, with a start/busy/done handshake toward the control sequencer.
- Single-cycle logic and add ops, plus multi-cycle unsigned shift-add multiply and restoring divide producing a double-width product or a quotient/remainder.
- Sits between the buffer register (operand source) and the control unit, which issues one fn code per start pulse.

Parameters:
WIDTH, 16, data width of ACC, MR and operand (>=4)
CNTW, 5, iteration counter width; must hold WIDTH (default sized for 16)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE
fn  input  8  operation code, sampled with start
operand  input  WIDTH  [X] operand from buffer register, sampled with start
clr_acc  input  1  with start: ACC operand treated as 0 for this op
acc  output  WIDTH  accumulator
mr  output  WIDTH  multiply high half / divide remainder
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle completion pulse
zero  output  1  acc == 0, updated with acc
neg  output  1  acc[WIDTH-1], updated with acc
div_zero  output  1  last op was divide by zero; held until next completion
illegal  output  1  last fn was unrecognised; held until next completion

Behaviour:
- Reset (rst==0 at a rising edge): acc=0, mr=0, busy=0, done=0, zero=1, neg=0, div_zero=0, illegal=0; state=IDLE. Overrides everything, including an op in flight; an aborted op produces no done pulse.
- States: IDLE, MUL, DIV.
- Accept: edge T0 with state IDLE and start=1. Latch fn, operand and A = clr_acc ? 0 : acc. start during MUL/DIV is ignored, not queued.
- Single-cycle ops complete at T0; acc/flags/done are valid in the following cycle, and mr is unchanged:
  - 0x02: acc=X.
  - 0x03: acc=A+X.
  - 0x04: acc=A-X (mod 2^WIDTH).
  - 0x0A: acc=A&X.
  - 0x0B: acc=A|X.
  - 0x0C: acc=~X.
  - 0x0D: acc=A>>1 logical (MSB=0).
  - 0x0E: acc=A<<1 logical.
  - 0x0F: acc=~A.
- No-op codes 0x01, 0x05, 0x06, 0x07 (store/branch/halt, handled elsewhere): done pulse only; acc, mr and flags unchanged; div_zero=0, illegal=0.
- Any other code: done pulse, illegal=1; acc and mr unchanged.
- 0x08 MUL (unsigned):
  - At T0: state=MUL, busy=1, counter=0.
  - One shift-add iteration per edge T1..T(WIDTH).
  - At T(WIDTH): {mr,acc} = A*X (2*WIDTH bits), done=1, busy=0, state=IDLE.
  - busy is high for exactly WIDTH cycles.
- 0x09 DIV (unsigned restoring), X != 0:
  - Same timing as MUL.
  - Result: acc = A/X, mr = A%X.
- 0x09 DIV, X == 0:
  - No iteration; completes at T0.
  - acc = all ones, mr = A, div_zero=1, busy stays 0.
- Every completion:
  - zero/neg recomputed from the new acc value.
  - div_zero and illegal rewritten (0 unless set by this op).
  - done high for exactly one cycle.
- Intermediate multiply/divide state is internal; acc and mr hold their pre-op values until the completing edge.
- Operand, fn and clr_acc changes while busy have no effect.
- Back-to-back: start may be high in the cycle done is high; it is accepted (state is IDLE).

Test Plan:
- Hold rst=0 two edges with start=1, fn=0x03 -> acc=0x0000, mr=0x0000, zero=1, busy=0, done never pulses; release, start fn=0x02 X=0x0005 -> acc=0x0005 and done one cycle after the accept edge.
- acc=0x0003, fn=0x04 X=0x0005 -> acc=0xFFFE, neg=1, zero=0; then fn=0x03 X=0x0002 -> acc=0x0000, zero=1, neg=0.
- acc=0x1234, fn=0x08 X=0x0100 -> busy high 16 cycles, acc unchanged meanwhile, then acc=0x3400, mr=0x0012, single done; a start pulse mid-op is ignored.
- acc=0x0064, fn=0x09 X=0x0007 -> after 16 busy cycles acc=0x000E, mr=0x0002; then acc=0x0010, fn=0x09 X=0 -> next cycle acc=0xFFFF, mr=0x0010, div_zero=1, busy never asserted.
- fn=0x0D then 0x0E on acc=0x8001 -> 0x4000 then 0x8000; fn=0x0F with clr_acc=1 -> acc=0xFFFF; fn=0x20 -> illegal=1, acc unchanged; next fn=0x01 -> illegal=0, done pulse.
- Start MUL, drive rst=0 at the 5th busy cycle -> next edge acc=0, mr=0, busy=0, no done; the following start is accepted normally.
